// File: rtl/whack_round_ctrl_pkg.sv
// Shared definitions for the whack-a-target game: FSM state encoding, keypad codes
// for the four targets and the LFSR feedback mask. Also used by the keypad scanner
// and the score decoder.
package whack_round_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StShow = 2'd1,
        StGap  = 2'd2,
        StDone = 2'd3
    } state_e;

    // Keypad codes that select targets 0..3.
    localparam logic [3:0] KeyT0 = 4'd1;
    localparam logic [3:0] KeyT1 = 4'd2;
    localparam logic [3:0] KeyT2 = 4'd3;
    localparam logic [3:0] KeyT3 = 4'd4;

    // Right-shift Galois mask for x^8 + x^6 + x^5 + x^4 + 1.
    localparam logic [7:0] LfsrTaps = 8'hB8;

    function automatic logic [3:0] key_for_target(input logic [1:0] t);
        logic [3:0] k;
        unique case (t)
            2'd0:    k = KeyT0;
            2'd1:    k = KeyT1;
            2'd2:    k = KeyT2;
            default: k = KeyT3;
        endcase
        return k;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {1'b0, v[7:1]} ^ (v[0] ? LfsrTaps : 8'h00);
    endfunction

endpackage

// File: rtl/whack_lfsr.sv
// Free-running 8-bit Galois LFSR used to pick the next target.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset, loads SEED
//   pick - low two bits of the current LFSR state (target candidate)
module whack_lfsr
    import whack_round_ctrl_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] pick
);

    logic [7:0] lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign pick = lfsr_q[1:0];

endmodule

// File: rtl/whack_round_ctrl.sv
// Game sequencer for the keypad "hit the lit target" game. Lights a pseudo-random
// target for SHOW_TICKS cycles, judges exactly one keypad press per target, blanks
// for GAP_TICKS cycles, and ends the game after ROUNDS targets.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   start                 - 1-cycle pulse, starts a game from IDLE or DONE
//   key_code, key_valid   - keypad value (1..4 = target 0..3) and key-held level
//   target, target_valid  - lit target and its qualifier (high in SHOW)
//   score, round_cnt      - hits this game (saturating) and targets presented
//   hit_pulse, miss_pulse - one judgement strobe per target
//   busy, game_over       - high in SHOW/GAP, high in DONE
module whack_round_ctrl
    import whack_round_ctrl_pkg::*;
#(
    parameter int unsigned SHOW_TICKS = 50_000_000,
    parameter int unsigned GAP_TICKS  = 12_500_000,
    parameter int unsigned ROUNDS     = 20,
    parameter int unsigned SCORE_MAX  = 9,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic [1:0] target,
    output logic       target_valid,
    output logic [3:0] score,
    output logic [7:0] round_cnt,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       busy,
    output logic       game_over
);

    localparam int unsigned MaxTicks = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int unsigned CntW     = $clog2(MaxTicks);

    localparam logic [CntW-1:0] ShowLast   = CntW'(SHOW_TICKS - 1);
    localparam logic [CntW-1:0] GapLast    = CntW'(GAP_TICKS - 1);
    localparam logic [7:0]      RoundsLast = 8'(ROUNDS);
    localparam logic [3:0]      ScoreTop   = 4'(SCORE_MAX);

    state_e          state_q;
    logic [CntW-1:0] dwell_q;
    logic            key_valid_q;
    logic [1:0]      lfsr_pick;
    logic            press;

    whack_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .pick (lfsr_pick)
    );

    // A held key produces a single press.
    assign press = key_valid & ~key_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            dwell_q      <= '0;
            key_valid_q  <= 1'b0;
            target       <= 2'd0;
            target_valid <= 1'b0;
            score        <= 4'd0;
            round_cnt    <= 8'd0;
            hit_pulse    <= 1'b0;
            miss_pulse   <= 1'b0;
            busy         <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            key_valid_q <= key_valid;
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;

            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q      <= StShow;
                        dwell_q      <= '0;
                        target       <= lfsr_pick;
                        target_valid <= 1'b1;
                        score        <= 4'd0;
                        round_cnt    <= 8'd1;
                        busy         <= 1'b1;
                        game_over    <= 1'b0;
                    end
                end

                StShow: begin
                    dwell_q <= dwell_q + 1'b1;
                    // A press on the final window cycle is judged, not timed out.
                    if (press || dwell_q == ShowLast) begin
                        state_q      <= StGap;
                        dwell_q      <= '0;
                        target_valid <= 1'b0;
                        if (press && key_code == key_for_target(target)) begin
                            hit_pulse <= 1'b1;
                            if (score < ScoreTop) begin
                                score <= score + 4'd1;
                            end
                        end else begin
                            miss_pulse <= 1'b1;
                        end
                    end
                end

                StGap: begin
                    dwell_q <= dwell_q + 1'b1;
                    if (dwell_q == GapLast) begin
                        dwell_q <= '0;
                        if (round_cnt == RoundsLast) begin
                            state_q   <= StDone;
                            busy      <= 1'b0;
                            game_over <= 1'b1;
                        end else begin
                            state_q      <= StShow;
                            round_cnt    <= round_cnt + 8'd1;
                            target       <= lfsr_pick;
                            target_valid <= 1'b1;
                        end
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_whack_round_ctrl.sv
module tb_whack_round_ctrl;

    localparam int unsigned ShowTicks = 8;
    localparam int unsigned GapTicks  = 3;
    localparam int unsigned Rounds    = 3;
    localparam int unsigned ScoreMaxA = 9;
    localparam int unsigned ScoreMaxB = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       key_valid = 1'b0;

    logic [1:0] target_a;
    logic       tv_a, hit_a, miss_a, busy_a, over_a;
    logic [3:0] score_a;
    logic [7:0] round_a;
    logic [1:0] target_b;
    logic       tv_b, hit_b, miss_b, busy_b, over_b;
    logic [3:0] score_b;
    logic [7:0] round_b;

    always #5 clk = ~clk;

    whack_round_ctrl #(
        .SHOW_TICKS (ShowTicks),
        .GAP_TICKS  (GapTicks),
        .ROUNDS     (Rounds),
        .SCORE_MAX  (ScoreMaxA),
        .LFSR_SEED  (8'hA5)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .target       (target_a),
        .target_valid (tv_a),
        .score        (score_a),
        .round_cnt    (round_a),
        .hit_pulse    (hit_a),
        .miss_pulse   (miss_a),
        .busy         (busy_a),
        .game_over    (over_a)
    );

    whack_round_ctrl #(
        .SHOW_TICKS (ShowTicks),
        .GAP_TICKS  (GapTicks),
        .ROUNDS     (Rounds),
        .SCORE_MAX  (ScoreMaxB),
        .LFSR_SEED  (8'hA5)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .target       (target_b),
        .target_valid (tv_b),
        .score        (score_b),
        .round_cnt    (round_b),
        .hit_pulse    (hit_b),
        .miss_pulse   (miss_b),
        .busy         (busy_b),
        .game_over    (over_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: game phase, cycles left in the current window, expected outputs.
    int         m_mode;  // 0 idle, 1 show, 2 gap, 3 done
    int         m_left;
    bit         m_prev_kv;
    logic [7:0] m_lfsr;
    int         e_target, e_score_a, e_score_b, e_round;
    bit         e_hit, e_miss;

    function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
        logic [7:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 8'hB8;
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_prev_kv = 0; m_lfsr = 8'hA5;
        e_target = 0; e_score_a = 0; e_score_b = 0; e_round = 0;
        e_hit = 0; e_miss = 0;
    endtask

    task automatic model_step();
        bit press;
        press = key_valid && !m_prev_kv;
        e_hit = 0;
        e_miss = 0;
        case (m_mode)
            0, 3: if (start) begin
                m_mode = 1; m_left = ShowTicks; e_round = 1;
                e_score_a = 0; e_score_b = 0; e_target = int'(m_lfsr[1:0]);
            end
            1: begin
                m_left--;
                if (press || m_left == 0) begin
                    if (press && int'(key_code) == e_target + 1) begin
                        e_hit = 1;
                        if (e_score_a < ScoreMaxA) e_score_a++;
                        if (e_score_b < ScoreMaxB) e_score_b++;
                    end else begin
                        e_miss = 1;
                    end
                    m_mode = 2; m_left = GapTicks;
                end
            end
            2: begin
                m_left--;
                if (m_left == 0) begin
                    if (e_round == Rounds) m_mode = 3;
                    else begin
                        e_round++; m_mode = 1; m_left = ShowTicks;
                        e_target = int'(m_lfsr[1:0]);
                    end
                end
            end
            default: m_mode = 0;
        endcase
        m_prev_kv = key_valid;
        m_lfsr = lfsr_adv(m_lfsr);
    endtask

    task automatic check_all();
        if (m_mode == 1) chk("target", int'(target_a), e_target);
        chk("target_valid", int'(tv_a), int'(m_mode == 1));
        chk("score", int'(score_a), e_score_a);
        chk("round_cnt", int'(round_a), e_round);
        chk("hit_pulse", int'(hit_a), int'(e_hit));
        chk("miss_pulse", int'(miss_a), int'(e_miss));
        chk("busy", int'(busy_a), int'(m_mode == 1 || m_mode == 2));
        chk("game_over", int'(over_a), int'(m_mode == 3));
        chk("sat_score", int'(score_b), e_score_b);
        chk("sat_hit", int'(hit_b), int'(e_hit));
        chk("sat_miss", int'(miss_b), int'(e_miss));
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic do_cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        check_all();
    endtask

    // Called 1 time unit after an edge; asserts reset mid-cycle.
    task automatic pulse_reset();
        start = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("lfsr_seed", int'(dut_a.u_lfsr.lfsr_q), 'hA5);
        do_cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        bit         st;
        bit         good;
        logic [3:0] code;
        bit         kv;
        bit         tv, hit, miss, busy, over;
        int         score, round;
    } vec_t;

    vec_t tbl[17];

    task automatic apply_row(input vec_t v, input int idx);
        start = v.st;
        key_valid = v.kv;
        key_code = v.good ? 4'(e_target + 1) : v.code;
        do_cycle();
        chk($sformatf("row%0d_tv", idx), int'(tv_a), int'(v.tv));
        chk($sformatf("row%0d_hit", idx), int'(hit_a), int'(v.hit));
        chk($sformatf("row%0d_miss", idx), int'(miss_a), int'(v.miss));
        chk($sformatf("row%0d_busy", idx), int'(busy_a), int'(v.busy));
        chk($sformatf("row%0d_over", idx), int'(over_a), int'(v.over));
        chk($sformatf("row%0d_score", idx), int'(score_a), v.score);
        chk($sformatf("row%0d_round", idx), int'(round_a), v.round);
    endtask

    task automatic idle_cycles(input int n);
        key_valid = 1'b0;
        start = 1'b0;
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    initial begin
        //          st good code  kv  tv hit miss busy over score round
        tbl[0]  = '{1, 0, 4'd0, 0,  1, 0, 0, 1, 0, 0, 1};
        tbl[1]  = '{0, 1, 4'd0, 1,  0, 1, 0, 1, 0, 1, 1};
        tbl[2]  = '{0, 0, 4'd0, 0,  0, 0, 0, 1, 0, 1, 1};
        tbl[3]  = '{0, 0, 4'd0, 0,  0, 0, 0, 1, 0, 1, 1};
        tbl[4]  = '{0, 0, 4'd0, 0,  1, 0, 0, 1, 0, 1, 2};
        tbl[5]  = '{0, 0, 4'd7, 1,  0, 0, 1, 1, 0, 1, 2};
        tbl[6]  = '{0, 0, 4'd7, 1,  0, 0, 0, 1, 0, 1, 2};
        tbl[7]  = '{0, 0, 4'd7, 1,  0, 0, 0, 1, 0, 1, 2};
        tbl[8]  = '{0, 0, 4'd7, 1,  1, 0, 0, 1, 0, 1, 3};
        tbl[9]  = '{0, 1, 4'd0, 1,  1, 0, 0, 1, 0, 1, 3};
        tbl[10] = '{0, 0, 4'd0, 0,  1, 0, 0, 1, 0, 1, 3};
        tbl[11] = '{0, 1, 4'd0, 1,  0, 1, 0, 1, 0, 2, 3};
        tbl[12] = '{0, 0, 4'd0, 0,  0, 0, 0, 1, 0, 2, 3};
        tbl[13] = '{0, 0, 4'd0, 0,  0, 0, 0, 1, 0, 2, 3};
        tbl[14] = '{0, 0, 4'd0, 0,  0, 0, 0, 0, 1, 2, 3};
        tbl[15] = '{0, 0, 4'd0, 0,  0, 0, 0, 0, 1, 2, 3};
        tbl[16] = '{1, 0, 4'd0, 0,  1, 0, 0, 1, 0, 0, 1};

        // Power-on reset
        model_reset();
        #1;
        check_all();
        do_cycle();
        do_cycle();
        rst = 1'b0;
        idle_cycles(2);

        for (int i = 0; i < 17; i++) apply_row(tbl[i], i);
        start = 1'b0;

        // Timeout: miss exactly on the 8th window cycle
        key_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            do_cycle();
            chk("timeout_wait_miss", int'(miss_a), 0);
        end
        do_cycle();
        chk("timeout_miss", int'(miss_a), 1);
        chk("timeout_tv", int'(tv_a), 0);
        idle_cycles(3);
        chk("round2_tv", int'(tv_a), 1);
        chk("round2_cnt", int'(round_a), 2);

        // Correct press on the last window cycle: hit wins over timeout
        idle_cycles(7);
        key_valid = 1'b1;
        key_code = 4'(e_target + 1);
        do_cycle();
        chk("late_hit", int'(hit_a), 1);
        chk("late_no_miss", int'(miss_a), 0);
        idle_cycles(1);
        chk("late_no_miss2", int'(miss_a), 0);

        // Reset in SHOW of round 3
        idle_cycles(2);
        chk("pre_rst_show", int'(tv_a), 1);
        idle_cycles(2);
        pulse_reset();
        chk("post_rst_round", int'(round_a), 0);
        idle_cycles(3);

        // Three hits: full game, saturation on the SCORE_MAX=2 instance
        start = 1'b1;
        do_cycle();
        start = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            key_valid = 1'b1;
            key_code = 4'(e_target + 1);
            do_cycle();
            chk("sat_hit_pulse", int'(hit_b), 1);
            chk("sat_score_val", int'(score_b), (r < 2) ? r : 2);
            chk("full_score_val", int'(score_a), r);
            key_valid = 1'b0;
            start = 1'b1;  // ignored while busy
            do_cycle();
            start = 1'b0;
            do_cycle();
            do_cycle();
        end
        chk("end_over", int'(over_a), 1);
        chk("end_busy", int'(busy_a), 0);
        chk("end_score", int'(score_a), 3);
        chk("end_round", int'(round_a), 3);
        idle_cycles(4);
        chk("held_score", int'(score_a), 3);
        start = 1'b1;
        do_cycle();
        start = 1'b0;
        chk("restart_score", int'(score_a), 0);
        chk("restart_round", int'(round_a), 1);

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                pulse_reset();
            end else begin
                start = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 3) == 0) begin
                    key_valid = ~key_valid;
                    if (key_valid) begin
                        if ($urandom_range(0, 1) == 0) key_code = 4'(e_target + 1);
                        else key_code = 4'($urandom_range(0, 15));
                    end
                end
                do_cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
